// File: rtl/gpuni_noc_pkg.sv
// Shared NoC egress definitions: default geometry of the spine scheduler and its
// pause-handshake state encoding.
package gpuni_noc_pkg;

  localparam int DEF_DWIDTH     = 16;
  localparam int DEF_NUM_SPINES = 4;
  localparam int DEF_CREDITS    = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;
  int            sum;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < N; i++) begin
      // ptr is always below N, so one conditional subtract is enough to wrap
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spine_egress_scheduler.sv
// Spreads NI flits round-robin over credit-managed spine uplinks with one cycle of
// latency, and supports a pause handshake that waits for all credits to come home.
module spine_egress_scheduler
  import gpuni_noc_pkg::*;
#(
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int NUM_SPINES = DEF_NUM_SPINES,
  parameter int CREDITS    = DEF_CREDITS
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [DWIDTH-1:0]            ni_data,
  input  logic                         ni_valid,
  output logic                         ni_ready,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_credit_ret,
  input  logic [NUM_SPINES-1:0]        cfg_spine_en,
  input  logic                         pause_req,
  output logic                         pause_ack,
  output logic                         credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1;

  sched_state_e state, state_next;

  logic [CW-1:0]                credit [NUM_SPINES];
  logic [PW-1:0]                rr_ptr;
  logic [PW-1:0]                gidx;
  logic [NUM_SPINES-1:0]        eligible;
  logic [NUM_SPINES-1:0]        grant;
  logic [NUM_SPINES-1:0]        full;
  logic [NUM_SPINES-1:0]        vld_p1;
  logic [NUM_SPINES*DWIDTH-1:0] data_p1;
  logic                         xfer;
  logic                         err_q;

  always_comb begin
    for (int i = 0; i < NUM_SPINES; i++) begin
      eligible[i] = cfg_spine_en[i] && (credit[i] != '0);
      full[i]     = (credit[i] == CW'(CREDITS));
    end
  end

  rr_arbiter #(.N(NUM_SPINES), .PW(PW)) u_rr_arbiter (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign xfer = ni_valid && ni_ready;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Returning to RUN beats completing the drain when the request drops.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:    if (pause_req) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (!pause_req)                       state_next = ST_RUN;
        else if ((&full) && (vld_p1 == '0))   state_next = ST_PAUSED;
      end
      ST_PAUSED: if (!pause_req) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    ni_ready  = (state == ST_RUN) && (|eligible);
    pause_ack = (state == ST_PAUSED);
  end

  // Stage p1: registered spine outputs, round-robin pointer and credit accounting
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vld_p1  <= '0;
      data_p1 <= '0;
      rr_ptr  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_SPINES; i++) credit[i] <= CW'(CREDITS);
    end else begin
      vld_p1 <= xfer ? grant : '0;
      if (xfer) rr_ptr <= (gidx == PW'(NUM_SPINES - 1)) ? '0 : gidx + PW'(1);
      for (int i = 0; i < NUM_SPINES; i++) begin
        if (xfer && grant[i]) data_p1[i*DWIDTH +: DWIDTH] <= ni_data;
        if ((xfer && grant[i]) && !spine_credit_ret[i]) begin
          credit[i] <= credit[i] - CW'(1);
        end else if (!(xfer && grant[i]) && spine_credit_ret[i]) begin
          if (full[i]) err_q     <= 1'b1;
          else         credit[i] <= credit[i] + CW'(1);
        end
      end
    end
  end

  assign spine_out_valid = vld_p1;
  assign spine_out_data  = data_p1;
  assign credit_err      = err_q;

endmodule

// File: tb/tb_spine_egress_scheduler.sv
// Bench for spine_egress_scheduler: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_spine_egress_scheduler;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [15:0] ni_data = '0;
  logic        ni_valid = 1'b0;
  logic        ni_ready;
  logic [63:0] spine_out_data;
  logic [3:0]  spine_out_valid;
  logic [3:0]  spine_credit_ret = '0;
  logic [3:0]  cfg_spine_en = 4'hF;
  logic        pause_req = 1'b0;
  logic        pause_ack;
  logic        credit_err;

  int n_checks = 0;
  int n_err    = 0;

  spine_egress_scheduler dut (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .ni_data          (ni_data),
    .ni_valid         (ni_valid),
    .ni_ready         (ni_ready),
    .spine_out_data   (spine_out_data),
    .spine_out_valid  (spine_out_valid),
    .spine_credit_ret (spine_credit_ret),
    .cfg_spine_en     (cfg_spine_en),
    .pause_req        (pause_req),
    .pause_ack        (pause_ack),
    .credit_err       (credit_err)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: 0=run, 1=drain, 2=paused
  int          m_cred [4];
  int          m_rr;
  int          m_st;
  bit          m_err;
  logic [3:0]  m_vld;
  logic [63:0] m_data;

  function automatic void m_reset();
    for (int s = 0; s < 4; s++) m_cred[s] = 4;
    m_rr = 0; m_st = 0; m_err = 0; m_vld = '0; m_data = '0;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (m_rr + k) % 4;
      if (cfg_spine_en[s] && m_cred[s] > 0) return s;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    return (m_st == 0) && (m_pick() >= 0);
  endfunction

  function automatic void m_update();
    bit x;
    int g;
    bit all_full;
    logic [3:0] old_vld;
    x = ni_valid && m_ready();
    g = m_pick();
    old_vld = m_vld;
    all_full = 1;
    for (int s = 0; s < 4; s++) if (m_cred[s] != 4) all_full = 0;
    m_vld = '0;
    if (x) begin
      m_vld[g] = 1'b1;
      m_data[g*16 +: 16] = ni_data;
      m_rr = (g + 1) % 4;
    end
    for (int s = 0; s < 4; s++) begin
      bit snd;
      snd = x && (g == s);
      if (snd && !spine_credit_ret[s]) m_cred[s]--;
      else if (!snd && spine_credit_ret[s]) begin
        if (m_cred[s] == 4) m_err = 1;
        else m_cred[s]++;
      end
    end
    case (m_st)
      0: if (pause_req) m_st = 1;
      1: if (!pause_req) m_st = 0; else if (all_full && old_vld == 0) m_st = 2;
      default: if (!pause_req) m_st = 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    chk("spine_out_valid", 64'(spine_out_valid), 64'(m_vld));
    chk("spine_out_data", spine_out_data, m_data);
    chk("pause_ack", 64'(pause_ack), 64'(m_st == 2));
    chk("credit_err", 64'(credit_err), 64'(m_err));
    for (int s = 0; s < 4; s++) chk("credit", 64'(dut.credit[s]), 64'(m_cred[s]));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("ni_ready", 64'(ni_ready), 64'(m_ready()));
    @(posedge ACLK);
    m_update();
    #1;
    chk_outputs();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    ni_valid = 1'b0; spine_credit_ret = '0; pause_req = 1'b0;
    m_reset();
    @(posedge ACLK);
    #1;
    chk_outputs();
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic        valid;
    logic [3:0]  ret;
    logic [15:0] data;
    logic        exp_ready;
    logic [3:0]  exp_vld;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{4'b0101, 1'b1, 4'b0000, 16'h1111, 1'b1, 4'b0001};
    tbl[1] = '{4'b0101, 1'b1, 4'b0001, 16'h2222, 1'b1, 4'b0100};
    tbl[2] = '{4'b0101, 1'b1, 4'b0100, 16'h3333, 1'b1, 4'b0001};
    tbl[3] = '{4'b0101, 1'b1, 4'b0001, 16'h4444, 1'b1, 4'b0100};
    tbl[4] = '{4'b0000, 1'b1, 4'b0100, 16'h5555, 1'b0, 4'b0000};
    tbl[5] = '{4'b1000, 1'b0, 4'b0000, 16'h6666, 1'b1, 4'b0000};
    tbl[6] = '{4'b1000, 1'b1, 4'b0000, 16'h7777, 1'b1, 4'b1000};

    m_reset();
    @(negedge ACLK);
    do_reset();

    // Vector table: alternating 0/2 mask, all-disabled, single-spine
    for (int i = 0; i < 7; i++) begin
      cfg_spine_en = tbl[i].en; ni_valid = tbl[i].valid;
      spine_credit_ret = tbl[i].ret; ni_data = tbl[i].data;
      #1;
      chk("tbl_ready", 64'(ni_ready), 64'(tbl[i].exp_ready));
      @(posedge ACLK); m_update(); #1;
      chk("tbl_vld", 64'(spine_out_valid), 64'(tbl[i].exp_vld));
      for (int s = 0; s < 4; s++)
        if (tbl[i].exp_vld[s]) chk("tbl_data", 64'(spine_out_data[s*16 +: 16]), 64'(tbl[i].data));
      chk_outputs();
      @(negedge ACLK);
    end

    // 16 flits round-robin with no returns, then stall
    do_reset();
    cfg_spine_en = 4'hF; ni_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ni_data = 16'(16'h0100 + k);
      step();
      if (k < 16) chk("rr16_grant", 64'(spine_out_valid), 64'(4'b0001 << (k % 4)));
      else        chk("rr16_stall", 64'(spine_out_valid), 64'h0);
    end
    #1; chk("rr16_ready_low", 64'(ni_ready), 64'h0);

    // Simultaneous send and return on spine 1 at credit 2
    do_reset();
    cfg_spine_en = 4'b0010; ni_valid = 1'b1;
    step(); step();
    chk("c1_at2", 64'(dut.credit[1]), 64'd2);
    spine_credit_ret = 4'b0010;
    step();
    chk("c1_hold", 64'(dut.credit[1]), 64'd2);
    chk("c1_sent", 64'(spine_out_valid), 64'b0010);
    ni_valid = 1'b0; spine_credit_ret = '0;

    // Credit return at full count is sticky error
    do_reset();
    cfg_spine_en = 4'hF; spine_credit_ret = 4'b1000;
    step();
    spine_credit_ret = '0;
    chk("err_set", 64'(credit_err), 64'h1);
    chk("c3_full", 64'(dut.credit[3]), 64'd4);
    for (int k = 0; k < 3; k++) step();
    chk("err_sticky", 64'(credit_err), 64'h1);
    do_reset();
    chk("err_cleared", 64'(credit_err), 64'h0);

    // Pause with three credits outstanding
    cfg_spine_en = 4'hF; ni_valid = 1'b1;
    step(); step(); step();
    ni_valid = 1'b0; pause_req = 1'b1;
    step();
    #1; chk("pause_ready_low", 64'(ni_ready), 64'h0);
    spine_credit_ret = 4'b0001; step();
    spine_credit_ret = 4'b0010; step();
    spine_credit_ret = 4'b0100; step();
    chk("pause_ack_early", 64'(pause_ack), 64'h0);
    spine_credit_ret = '0; step();
    chk("pause_ack_set", 64'(pause_ack), 64'h1);
    step();
    chk("pause_ack_hold", 64'(pause_ack), 64'h1);
    pause_req = 1'b0; step();
    chk("resume_ack", 64'(pause_ack), 64'h0);
    #1; chk("resume_ready", 64'(ni_ready), 64'h1);

    // Reset pulse coinciding with an accepted flit
    do_reset();
    cfg_spine_en = 4'hF; ni_valid = 1'b1; ni_data = 16'hA5C3;
    #1; chk("rst_mid_ready", 64'(ni_ready), 64'h1);
    @(posedge ACLK);
    ARESETn = 1'b0;
    m_reset();
    #1;
    chk("rst_mid_vld", 64'(spine_out_valid), 64'h0);
    chk("rst_mid_data", spine_out_data, 64'h0);
    @(negedge ACLK);
    ARESETn = 1'b1; ni_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_post_vld", 64'(spine_out_valid), 64'h0);
    end
    for (int s = 0; s < 4; s++) chk("rst_post_credit", 64'(dut.credit[s]), 64'd4);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(9) == 0) cfg_spine_en = 4'($urandom);
      if ($urandom_range(24) == 0) pause_req = ~pause_req;
      ni_valid = ($urandom_range(3) != 0);
      ni_data = 16'($urandom);
      for (int s = 0; s < 4; s++) spine_credit_ret[s] = ($urandom_range(3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
